// File: rtl/wfifo_ingress_if.sv
// Stream, pointer and status signals between the upstream source / pointer block
// and the wfifo_ingress write-side stage.
interface wfifo_ingress_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
);
    logic             s_valid;
    logic             s_ready;
    logic [DSIZE-1:0] s_data;
    logic             wfull;
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   wq2_rptr;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic [ASIZE:0]   wlevel;
    logic             walmost_full;
    logic [15:0]      wstall_cnt;

    modport master (
        output s_valid, s_data, wfull, wptr, wq2_rptr,
        input  s_ready, winc, wdata, wlevel, walmost_full, wstall_cnt
    );

    modport slave (
        input  s_valid, s_data, wfull, wptr, wq2_rptr,
        output s_ready, winc, wdata, wlevel, walmost_full, wstall_cnt
    );
endinterface

// File: rtl/wfifo_ingress.sv
// Write-side ingress of the async FIFO: 2-entry skid buffer feeding winc/wdata plus
// gray-pointer fill level. Define WFIFO_STALL_CNT_EN to build the saturating stall counter.
module wfifo_ingress #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned ASIZE     = 4,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic           wclk,
    input  logic           wrst,
    wfifo_ingress_if.slave bus
);

    localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_THRESH);

    logic [1:0]            cnt_q, cnt_d;
    logic [1:0][DSIZE-1:0] buf_q, buf_d;
    logic                  s_ready_q;
    logic                  push, pop;

    logic [ASIZE:0]        wbin, rbin;
    logic [ASIZE:0]        level_q, level_d;
    logic                  af_q, af_d;

    assign push = bus.s_valid && s_ready_q;
    assign pop  = (cnt_q != 2'd0) && !bus.wfull;

    // Entry 0 is always the head; it is left untouched on the last pop so wdata holds.
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    buf_d[0] = bus.s_data;
                    cnt_d    = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    buf_d[0] = bus.s_data;
                end else if (push) begin
                    buf_d[1] = bus.s_data;
                    cnt_d    = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    buf_d[0] = buf_q[1];
                    cnt_d    = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            cnt_q     <= '0;
            buf_q     <= '0;
            s_ready_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            s_ready_q <= (cnt_d != 2'd2);
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.winc    = pop;
    assign bus.wdata   = buf_q[0];

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b = '0;
        for (int unsigned i = 0; i <= ASIZE; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    assign wbin = gray2bin(bus.wptr);
    assign rbin = gray2bin(bus.wq2_rptr);

    // Modular subtraction absorbs pointer wrap; stale rptr only ever overstates the level.
    assign level_d = wbin - rbin;
    assign af_d    = (level_d >= AF_LVL);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            level_q <= '0;
            af_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            af_q    <= af_d;
        end
    end

    assign bus.wlevel       = level_q;
    assign bus.walmost_full = af_q;

`ifdef WFIFO_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_q <= '0;
        end else if ((cnt_q != 2'd0) && bus.wfull && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.wstall_cnt = stall_q;
`else
    assign bus.wstall_cnt = '0;
`endif

endmodule

// File: tb/tb_wfifo_ingress.sv
// Self-checking bench for wfifo_ingress: directed scenarios plus random traffic against
// a queue-based model of the skid buffer and an integer model of the pointer block.
module tb_wfifo_ingress;

    logic clk;
    logic rst;

    wfifo_ingress_if #(.DSIZE(8), .ASIZE(4)) bus ();

    wfifo_ingress #(.DSIZE(8), .ASIZE(4), .AF_THRESH(12)) dut (
        .wclk (clk),
        .wrst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];    // model of words held in the ingress buffer
    logic [7:0] tx[$];    // words the upstream source still has to deliver
    logic [7:0] wlog[$];  // words observed on the write port
    int         wcyc[$];
    int         cyc = 0;
    int         wbin = 0;
    int         rbin = 0;
    int         exp_level = 0;
    int         exp_stall = 0;
    bit         chk_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic drive_ptrs();
        bus.wptr     = gray(wbin);
        bus.wq2_rptr = gray(rbin);
    endtask

    // One clock: check at the negedge, apply the edge to the model, drive inputs at edge+1.
    task automatic tick();
        bit exp_ready, exp_winc;
        #4;
        exp_ready = (mq.size() < 2);
        exp_winc  = (mq.size() > 0) && !bus.wfull;
        if (chk_en) begin
            chk("s_ready", bus.s_ready, exp_ready);
            chk("winc", bus.winc, exp_winc);
            if (exp_winc) chk("wdata", bus.wdata, mq[0]);
            chk("wlevel", bus.wlevel, exp_level);
            chk("walmost_full", bus.walmost_full, exp_level >= 12);
            chk("wstall_cnt", bus.wstall_cnt, exp_stall);
        end
        if (bus.winc === 1'b1) begin
            wlog.push_back(bus.wdata);
            wcyc.push_back(cyc);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_level = 0;
            exp_stall = 0;
            wbin = 0;
            rbin = 0;
            chk_en = 1;
        end else begin
`ifdef WFIFO_STALL_CNT_EN
            if (mq.size() > 0 && bus.wfull && exp_stall < 65535) exp_stall++;
`endif
            exp_level = (wbin - rbin) & 31;
            if (exp_winc) void'(mq.pop_front());
            if (bus.s_valid && exp_ready) begin
                mq.push_back(bus.s_data);
                void'(tx.pop_front());
            end
            if (exp_winc) wbin++;
        end
        #1;
        cyc++;
        drive_ptrs();
        bus.s_valid = (tx.size() > 0);
        bus.s_data  = (tx.size() > 0) ? tx[0] : 8'h00;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.wfull   = 1'b0;
        drive_ptrs();

        // 1: reset state
        do_reset(2);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_winc", bus.winc, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_wlevel", bus.wlevel, 0);
        chk("rst_af", bus.walmost_full, 0);
        chk("rst_stall", bus.wstall_cnt, 0);

        // 2: back-to-back stream 0x01..0x10 with wfull low
        wlog.delete(); wcyc.delete();
        for (int i = 1; i <= 16; i++) tx.push_back(8'(i));
        bus.s_valid = 1'b1;
        bus.s_data  = tx[0];
        c0 = cyc;
        repeat (20) tick();
        chk("t2_count", wlog.size(), 16);
        if (wlog.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("t2_data", wlog[i], i + 1);
            chk("t2_first", wcyc[0], c0 + 1);
            chk("t2_nogap", wcyc[15] - wcyc[0], 15);
        end
        chk("t2_level", bus.wlevel, 16);
        chk("t2_af", bus.walmost_full, 1);

        // 3: back-pressure from wfull
        do_reset(1);
        bus.wfull = 1'b1;
        tx = '{8'hA0, 8'hA1, 8'hA2};
        bus.s_valid = 1'b1;
        bus.s_data  = tx[0];
        wlog.delete(); wcyc.delete();
        repeat (3) tick();
        chk("t3_ready_lo", bus.s_ready, 0);
        chk("t3_winc_lo", bus.winc, 0);
        chk("t3_pending", bus.s_data, 8'hA2);
        bus.wfull = 1'b0;
        repeat (6) tick();
        chk("t3_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t3_w0", wlog[0], 8'hA0);
            chk("t3_w1", wlog[1], 8'hA1);
            chk("t3_w2", wlog[2], 8'hA2);
        end
        chk("t3_ready_hi", bus.s_ready, 1);

        // 4: level from gray pointers, including wrap
        do_reset(1);
        wbin = 12; rbin = 0;
        drive_ptrs();
        chk("t4_wptr_gray", bus.wptr, 5'b01010);
        tick();
        chk("t4_lvl12", bus.wlevel, 12);
        chk("t4_af12", bus.walmost_full, 1);
        wbin = 11;
        drive_ptrs();
        tick();
        chk("t4_lvl11", bus.wlevel, 11);
        chk("t4_af11", bus.walmost_full, 0);
        wbin = 3; rbin = 19;
        drive_ptrs();
        chk("t4_rptr_gray", bus.wq2_rptr, 5'b11010);
        tick();
        chk("t4_lvl16", bus.wlevel, 16);
        chk("t4_af16", bus.walmost_full, 1);

        // 5: reset discards buffered words
        do_reset(1);
        bus.wfull = 1'b1;
        tx = '{8'h55, 8'h66};
        bus.s_valid = 1'b1;
        bus.s_data  = tx[0];
        repeat (3) tick();
        chk("t5_full_buf", bus.s_ready, 0);
        tx.delete();
        bus.s_valid = 1'b0;
        do_reset(1);
        bus.wfull = 1'b0;
        chk("t5_ready", bus.s_ready, 1);
        chk("t5_winc", bus.winc, 0);
        wlog.delete();
        repeat (4) tick();
        chk("t5_nowrite", wlog.size(), 0);

        // 6: stall counter
        do_reset(1);
        bus.wfull = 1'b1;
        tx = '{8'h77};
        bus.s_valid = 1'b1;
        bus.s_data  = tx[0];
        tick();
        repeat (5) tick();
`ifdef WFIFO_STALL_CNT_EN
        chk("t6_stall5", bus.wstall_cnt, 5);
        repeat (70000) tick();
        chk("t6_sat", bus.wstall_cnt, 16'hFFFF);
`else
        chk("t6_tied", bus.wstall_cnt, 0);
`endif
        bus.wfull = 1'b0;
        repeat (3) tick();

        // random traffic
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if (tx.size() == 0 && $urandom_range(0, 3) != 0) begin
                tx.push_back(8'($urandom));
                bus.s_valid = 1'b1;
                bus.s_data  = tx[0];
            end
            bus.wfull = ($urandom_range(0, 2) == 0);
            if (rbin < wbin && $urandom_range(0, 1) == 1) rbin++;
            drive_ptrs();
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
